// File: rtl/uart_pkg.sv
// Shared UART definitions used by uart_tx, the baud generator and uart_rx.
// Contents:
//   UART_DATA_BITS - default payload bits per frame
//   UART_OS_RATE   - default oversample ticks per bit period
//   rx_state_e     - receiver FSM states
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam int unsigned UART_OS_RATE   = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Input conditioning for the UART receiver. It brings the asynchronous serial
// line into the clk domain and detects its falling edges.
// Ports:
//   clk     - system clock
//   rst     - synchronous active-high reset (every stage resets to idle-high)
//   rx_line - asynchronous serial input, idle high
//   synced  - rx_line after the two synchronizer stages
//   fall    - high while the edge register holds 1 and synced is 0
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx_line,
  output logic synced,
  output logic fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = rx_line;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // NOTE: all stages reset to 1 (the idle level). A reset value of 0 would
  // look like a falling edge and start a frame as soon as reset releases.
  // NOTE: sequential state is updated only with non-blocking assignments, so
  // each stage captures the value its upstream stage held before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign synced = sync_q;
  assign fall   = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART 8N1 receiver. It runs on clk and counts bit timing with an oversample
// strobe (OS_RATE strobes per bit). Each byte is presented on data_out with a
// one-cycle valid strobe. A start bit that is no longer low at its centre is
// rejected as a glitch. A stop bit that is sampled low is reported as a
// framing error.
// Ports:
//   clk       - system clock, rising edge
//   rst       - synchronous active-high reset
//   os_tick   - oversample strobe, one-cycle pulse, OS_RATE per bit
//   rx_line   - asynchronous serial input, idle high
//   data_out  - last received payload, updated at every stop-bit sample
//   rx_valid  - one-cycle pulse: data_out holds a good frame
//   frame_err - one-cycle pulse: the stop bit was sampled low
//   rx_busy   - high from start detect until the FSM returns to IDLE
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = UART_DATA_BITS,
  parameter int unsigned OS_RATE   = UART_OS_RATE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 os_tick,
  input  logic                 rx_line,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 rx_busy
);

  localparam int unsigned TICK_W = $clog2(OS_RATE);
  localparam int unsigned BIT_W  = $clog2(DATA_BITS + 1);

  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OS_RATE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OS_RATE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  logic synced;
  logic fall;

  uart_rx_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .rx_line (rx_line),
    .synced  (synced),
    .fall    (fall)
  );

  rx_state_e            state_q, state_d;
  logic [TICK_W-1:0]    tick_q,  tick_d;
  logic [BIT_W-1:0]     bit_q,   bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q,  data_d;
  logic                 valid_q, valid_d;
  logic                 err_q,   err_d;

  // NOTE: every signal gets a default before the case statement. Each path
  // then assigns only what it changes, and no latch can be inferred.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // os_tick is ignored here; only a fresh falling edge re-arms.
        if (fall) begin
          state_d = START;
          tick_d  = '0;
        end
      end

      START: begin
        if (os_tick) begin
          if (tick_q == TICK_HALF) begin
            // Re-check at the start-bit centre. A line that is high again
            // was a glitch.
            if (synced) begin
              state_d = IDLE;
            end else begin
              state_d = DATA;
              tick_d  = '0;
              bit_d   = '0;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end

      DATA: begin
        if (os_tick) begin
          if (tick_q == TICK_LAST) begin
            // LSB arrives first, so shift in from the top. After DATA_BITS
            // samples, bit 0 sits at index 0.
            shift_d = {synced, shift_q[DATA_BITS-1:1]};
            tick_d  = '0;
            bit_d   = bit_q + 1'b1;
            if (bit_q == BIT_LAST) begin
              state_d = STOP;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end

      STOP: begin
        if (os_tick) begin
          if (tick_q == TICK_LAST) begin
            // Return to IDLE at mid-stop-bit so that a start bit directly
            // after the stop bit is still detected.
            data_d  = shift_q;
            valid_d = synced;
            err_d   = ~synced;
            tick_d  = '0;
            state_d = IDLE;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign data_out  = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = err_q;
  // rx_busy comes straight from the state register. It falls on the same edge
  // that the strobe rises.
  assign rx_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx. An inline transmitter model drives rx_line.
// os_tick pulses once every 4 clk cycles. Each line change happens one clk
// after an os_tick, and each bit lasts a whole number of os_ticks.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int OS = UART_OS_RATE;

  logic       clk = 1'b0;
  logic       rst;
  logic       os_tick;
  logic       rx_line;
  logic [7:0] data_out;
  logic       rx_valid;
  logic       frame_err;
  logic       rx_busy;

  always #5 clk = ~clk;

  uart_rx #(.DATA_BITS(8), .OS_RATE(OS)) dut (
    .clk       (clk),
    .rst       (rst),
    .os_tick   (os_tick),
    .rx_line   (rx_line),
    .data_out  (data_out),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  int n_cmp = 0;
  int n_err = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  logic [7:0] rx_log[$];

  // Counts strobe cycles. A strobe wider than one cycle inflates the count.
  always @(negedge clk) begin
    if (rx_valid) begin
      valid_cnt++;
      rx_log.push_back(data_out);
    end
    if (frame_err) err_cnt++;
  end

  initial begin
    os_tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      os_tick = 1'b1;
      @(negedge clk);
      os_tick = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive v, then wait n os_ticks plus one clk. Back-to-back calls therefore
  // change the line exactly n tick periods apart.
  task automatic hold(input logic v, input int n);
    rx_line = v;
    repeat (n) begin
      do @(posedge clk); while (!os_tick);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic tick_align();
    do @(posedge clk); while (!os_tick);
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int bp);
    hold(1'b0, bp);
    for (int i = 0; i < 8; i++) hold(b[i], bp);
    hold(stop, bp);
  endtask

  int v0, e0, l0;

  initial begin
    rst     = 1'b1;
    rx_line = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("rst_data_out", data_out, 32'h0);
    check("rst_rx_valid", rx_valid, 32'h0);
    check("rst_frame_err", frame_err, 32'h0);
    check("rst_rx_busy", rx_busy, 32'h0);
    hold(1'b1, 4);

    // Glitch: low for 3 ticks, then high again before the start-bit centre
    tick_align();
    hold(1'b0, 3);
    check("glitch_busy_hi", rx_busy, 32'h1);
    hold(1'b1, 2 * OS);
    check("glitch_busy_lo", rx_busy, 32'h0);
    check("glitch_valid_cnt", valid_cnt, 32'd0);
    check("glitch_err_cnt", err_cnt, 32'd0);
    check("glitch_data_out", data_out, 32'h00);

    // Loopback 0xA5
    tick_align();
    send_frame(8'hA5, 1'b1, OS);
    check("a5_valid_cnt", valid_cnt, 32'd1);
    check("a5_data_out", data_out, 32'hA5);
    check("a5_err_cnt", err_cnt, 32'd0);
    check("a5_busy_lo", rx_busy, 32'h0);
    hold(1'b1, OS);

    // Framing error: 0x3C with a low stop bit, then the line held low (break)
    tick_align();
    send_frame(8'h3C, 1'b0, OS);
    hold(1'b0, 2 * OS);
    check("ferr_err_cnt", err_cnt, 32'd1);
    check("ferr_valid_cnt", valid_cnt, 32'd1);
    check("ferr_data_out", data_out, 32'h3C);
    check("ferr_busy_lo", rx_busy, 32'h0);
    hold(1'b1, OS);
    check("break_no_frame_v", valid_cnt, 32'd1);
    check("break_no_frame_e", err_cnt, 32'd1);

    // Back-to-back frames 0x00 and 0xFF
    l0 = rx_log.size();
    tick_align();
    send_frame(8'h00, 1'b1, OS);
    send_frame(8'hFF, 1'b1, OS);
    hold(1'b1, OS);
    check("b2b_valid_cnt", valid_cnt, 32'd3);
    check("b2b_log_size", rx_log.size(), l0 + 2);
    if (rx_log.size() >= l0 + 2) begin
      check("b2b_first", rx_log[l0], 32'h00);
      check("b2b_second", rx_log[l0+1], 32'hFF);
    end
    check("b2b_err_cnt", err_cnt, 32'd1);

    // Reset during data bit 4 of 0x81; the transmitter is reset too and idles
    v0 = valid_cnt;
    e0 = err_cnt;
    tick_align();
    hold(1'b0, OS);
    for (int i = 0; i < 4; i++) hold(1'(8'h81 >> i), OS);
    rx_line = 1'b0;  // bit 4 of 0x81
    repeat (8) begin
      do @(posedge clk); while (!os_tick);
    end
    check("mid_busy_hi", rx_busy, 32'h1);
    @(posedge clk);
    #1;
    rst     = 1'b1;
    rx_line = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_data_out", data_out, 32'h0);
    check("mid_rst_busy", rx_busy, 32'h0);
    check("mid_rst_valid", rx_valid, 32'h0);
    check("mid_rst_ferr", frame_err, 32'h0);
    hold(1'b1, 2 * OS);
    check("mid_no_strobe_v", valid_cnt, v0);
    check("mid_no_strobe_e", err_cnt, e0);
    tick_align();
    send_frame(8'h5A, 1'b1, OS);
    check("post_rst_valid_cnt", valid_cnt, v0 + 1);
    check("post_rst_data_out", data_out, 32'h5A);
    hold(1'b1, OS);

    // Slow transmitter: bit period OS+1 ticks
    v0 = valid_cnt;
    tick_align();
    send_frame(8'h96, 1'b1, OS + 1);
    hold(1'b1, OS);
    check("slow_valid_cnt", valid_cnt, v0 + 1);
    check("slow_data_out", data_out, 32'h96);
    check("slow_err_cnt", err_cnt, e0);
    check("slow_busy_lo", rx_busy, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
